// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler: FSM states, client count and id width.
package gcd_pkg;

    localparam int unsigned N_CLIENTS   = 2;
    localparam int unsigned CLIENT_ID_W = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CMP    = 3'd3,
        RESP   = 3'd4
    } state_e;

    // One-hot client vector from a client id.
    function automatic logic [N_CLIENTS-1:0] id_onehot(input logic [CLIENT_ID_W-1:0] id);
        return N_CLIENTS'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-client round-robin arbiter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req_i           request levels from both clients
//   update_i        strobe: record served_id_i as the last-served client
//   served_id_i     id of the client just served
//   grant_valid_c   combinational: some client is requesting
//   grant_id_c      combinational: id of the winning client
module rr_arbiter2
    import gcd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CLIENTS-1:0]   req_i,
    input  logic                   update_i,
    input  logic [CLIENT_ID_W-1:0] served_id_i,
    output logic                   grant_valid_c,
    output logic [CLIENT_ID_W-1:0] grant_id_c
);

    logic [CLIENT_ID_W-1:0] last_q;

    // Last-served pointer; starts at client 1 so client 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CLIENT_ID_W'(1);
        end else if (update_i) begin
            last_q <= served_id_i;
        end
    end

    // Lone requester wins; on a tie the client not served last wins.
    always_comb begin
        grant_valid_c = |req_i;
        grant_id_c    = '0;
        case (req_i)
            2'b10:   grant_id_c = CLIENT_ID_W'(1);
            2'b11:   grant_id_c = ~last_q;
            default: grant_id_c = '0;
        endcase
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Two-client GCD scheduler driving an external subtractive GCD datapath.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req, op_a0/op_b0/op_a1/op_b1  client request levels and operands
//   gnt                           one-cycle one-hot grant (operands captured)
//   dp_data_in, ldA, ldB,
//   sel1, sel2, sel_in            datapath operand and control outputs
//   lt, gt, eq, dp_result         datapath comparator flags and register A
//   rsp_valid, rsp_data           one-cycle one-hot result strobe and result
//   busy                          high whenever not IDLE
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CLIENTS-1:0] req,
    input  logic [WIDTH-1:0]     op_a0,
    input  logic [WIDTH-1:0]     op_b0,
    input  logic [WIDTH-1:0]     op_a1,
    input  logic [WIDTH-1:0]     op_b1,
    output logic [N_CLIENTS-1:0] gnt,
    output logic [WIDTH-1:0]     dp_data_in,
    output logic                 ldA,
    output logic                 ldB,
    output logic                 sel1,
    output logic                 sel2,
    output logic                 sel_in,
    input  logic                 lt,
    input  logic                 gt,
    input  logic                 eq,
    input  logic [WIDTH-1:0]     dp_result,
    output logic [N_CLIENTS-1:0] rsp_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 busy
);

    state_e                 state_q;
    logic [WIDTH-1:0]       op_a_q;
    logic [WIDTH-1:0]       op_b_q;
    logic [WIDTH-1:0]       result_q;
    logic [CLIENT_ID_W-1:0] owner_q;
    logic [N_CLIENTS-1:0]   gnt_q;
    logic [N_CLIENTS-1:0]   rsp_valid_q;

    logic                   arb_valid_c;
    logic [CLIENT_ID_W-1:0] arb_id_c;
    logic                   zero_op_c;

    rr_arbiter2 u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .update_i      (state_q == RESP),
        .served_id_i   (owner_q),
        .grant_valid_c (arb_valid_c),
        .grant_id_c    (arb_id_c)
    );

    assign zero_op_c = (op_a_q == '0) || (op_b_q == '0);

    // Sequencer: state, capture registers and the gnt/rsp strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_valid_c) begin
                        gnt_q   <= id_onehot(arb_id_c);
                        owner_q <= arb_id_c;
                        op_a_q  <= (arb_id_c == CLIENT_ID_W'(1)) ? op_a1 : op_a0;
                        op_b_q  <= (arb_id_c == CLIENT_ID_W'(1)) ? op_b1 : op_b0;
                        state_q <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (zero_op_c) begin
                        // With at least one operand zero, OR yields the other one.
                        result_q    <= op_a_q | op_b_q;
                        rsp_valid_q <= id_onehot(owner_q);
                        state_q     <= RESP;
                    end else begin
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: state_q <= CMP;
                CMP: begin
                    if (eq) begin
                        result_q    <= dp_result;
                        rsp_valid_q <= id_onehot(owner_q);
                        state_q     <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath control decode from state and flags (eq > lt > gt).
    always_comb begin
        dp_data_in = '0;
        ldA        = 1'b0;
        ldB        = 1'b0;
        sel1       = 1'b0;
        sel2       = 1'b0;
        sel_in     = 1'b0;
        case (state_q)
            LOAD_A: begin
                // Zero bypass spends this cycle deciding, so no load is issued.
                if (!zero_op_c) begin
                    sel_in     = 1'b1;
                    ldA        = 1'b1;
                    dp_data_in = op_a_q;
                end
            end
            LOAD_B: begin
                sel_in     = 1'b1;
                ldB        = 1'b1;
                dp_data_in = op_b_q;
            end
            CMP: begin
                if (eq) begin
                    ldA = 1'b0;
                end else if (lt) begin
                    sel1 = 1'b1;
                    ldB  = 1'b1;
                end else if (gt) begin
                    sel2 = 1'b1;
                    ldA  = 1'b1;
                end
            end
            default: begin
                ldA = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_scheduler.sv
// Self-checking bench for gcd_scheduler with a behavioural subtractive datapath.
module tb_gcd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] op_a0, op_b0, op_a1, op_b1;
    logic [1:0]  gnt;
    logic [15:0] dp_data_in;
    logic        ldA, ldB, sel1, sel2, sel_in;
    logic        lt, gt, eq;
    logic [15:0] dp_result;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gcd_scheduler #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
        .gnt(gnt), .dp_data_in(dp_data_in),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .lt(lt), .gt(gt), .eq(eq), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    // External datapath: registers A/B, input mux and direction-selected subtractor.
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [15:0] sub_v, din_v;
    assign sub_v     = sel1 ? (dp_b - dp_a) : (sel2 ? (dp_a - dp_b) : 16'd0);
    assign din_v     = sel_in ? dp_data_in : sub_v;
    assign lt        = dp_a < dp_b;
    assign gt        = dp_a > dp_b;
    assign eq        = dp_a == dp_b;
    assign dp_result = dp_a;
    always @(posedge clk) begin
        if (ldA) dp_a <= din_v;
        if (ldB) dp_b <= din_v;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: Euclid by division; subtract iterations = sum of quotients - 1.
    function automatic void ref_gcd(input int a, input int b, output int g, output int lat);
        int x, y, t, steps;
        if (a == 0 || b == 0) begin
            g   = (a == 0) ? b : a;
            lat = 1;
        end else begin
            x = a; y = b; steps = 0;
            while (y != 0) begin
                steps += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g   = x;
            lat = 3 + steps - 1;
        end
    endfunction

    task automatic wait_gnt(output logic ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rsp(output logic ok, output int lat, output logic saw_ld);
        ok = 1'b0; lat = 0; saw_ld = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid != 2'b00) begin ok = 1'b1; break; end
            if (ldA || ldB) saw_ld = 1'b1;
        end
    endtask

    task automatic run_txn(input int c, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_d, input int exp_lat, input string tag);
        logic ok, ld0, saw;
        int   cyc, lat;
        logic [1:0] mask;
        mask = (c == 0) ? 2'b01 : 2'b10;
        if (c == 0) begin op_a0 = a; op_b0 = b; end
        else        begin op_a1 = a; op_b1 = b; end
        req = mask;
        wait_gnt(ok, cyc);
        chk({tag, "_gnt_seen"}, 32'(ok), 1);
        if (!ok) begin req = 2'b00; return; end
        ld0 = ldA | ldB;
        req = 2'b00;
        chk({tag, "_gnt"}, 32'(gnt), 32'(mask));
        wait_rsp(ok, lat, saw);
        chk({tag, "_rsp_seen"}, 32'(ok), 1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(mask));
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat == 1) chk({tag, "_no_loads"}, 32'(ld0 | saw), 0);
    endtask

    typedef struct {
        int          client;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok, saw;
        int          cyc, lat, g, rl, c;
        logic [15:0] a, b;
        logic [1:0]  exp_g[3];
        logic [15:0] exp_r[3];

        vecs[0] = '{0, 16'd48, 16'd18, 16'd6,  7};
        vecs[1] = '{1, 16'd35, 16'd14, 16'd7,  6};
        vecs[2] = '{0, 16'd0,  16'd9,  16'd9,  1};
        vecs[3] = '{1, 16'd0,  16'd0,  16'd0,  1};
        vecs[4] = '{0, 16'd21, 16'd21, 16'd21, 3};
        vecs[5] = '{1, 16'd9,  16'd0,  16'd9,  1};
        vecs[6] = '{0, 16'd1,  16'd5,  16'd1,  7};

        rst_n = 1'b0; req = 2'b00;
        op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {gnt, rsp_valid, busy, ldA, ldB, sel1, sel2, sel_in}, 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie right after reset: client 0 first, then alternation 01, 10, 01.
        op_a0 = 16'd48; op_b0 = 16'd18; op_a1 = 16'd35; op_b1 = 16'd14;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_r[0] = 16'd6; exp_r[1] = 16'd7; exp_r[2] = 16'd6;
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(ok, cyc);
            chk($sformatf("tie%0d_gnt_seen", k), 32'(ok), 1);
            chk($sformatf("tie%0d_gnt", k), 32'(gnt), 32'(exp_g[k]));
            if (k > 0) chk($sformatf("tie%0d_gap", k), 32'(cyc), 2);
            wait_rsp(ok, lat, saw);
            chk($sformatf("tie%0d_rsp_valid", k), 32'(rsp_valid), 32'(exp_g[k]));
            chk($sformatf("tie%0d_rsp_data", k), 32'(rsp_data), 32'(exp_r[k]));
        end
        req = 2'b00;
        @(negedge clk);

        // Reset during CMP: outputs drop at once; next tie goes to client 0 again.
        op_a0 = 16'd300; op_b0 = 16'd1; req = 2'b01;
        wait_gnt(ok, cyc);
        req = 2'b00;
        repeat (5) @(negedge clk);
        chk("midop_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_outputs", {gnt, rsp_valid, busy, ldA, ldB, sel1, sel2, sel_in}, 0);
        chk("midop_rst_rsp_data", 32'(rsp_data), 0);
        chk("midop_rst_dp_data_in", 32'(dp_data_in), 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_a0 = 16'd48; op_b0 = 16'd18;
        req = 2'b11;
        wait_gnt(ok, cyc);
        chk("post_rst_tie_gnt", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        wait_rsp(ok, lat, saw);
        chk("post_rst_rsp_data", 32'(rsp_data), 6);
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_lat,
                    $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            c = int'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 150));
            b = 16'($urandom_range(1, 150));
            if ($urandom_range(0, 7) == 0) a = '0;
            if ($urandom_range(0, 7) == 0) b = '0;
            ref_gcd(int'(a), int'(b), g, rl);
            run_txn(c, a, b, 16'(g), rl, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
